data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/simple_processor_pkg.sv | 13 +
 rtl/dmem_array.sv | 29 ++
 rtl/data_mem_responder.sv | 109 ++++++++++
 tb/tb_data_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_processor_pkg.sv
// Shared processor-wide widths and the data-memory responder state encoding.
package simple_processor_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Data storage: asynchronous read, synchronous write, whole array cleared by reset.
module dmem_array #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: captures one request, waits LATENCY cycles, then
// issues a single-cycle ack (with err for out-of-range addresses).
module data_mem_responder
  import simple_processor_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int unsigned MEM_DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH          = 64,
  parameter int unsigned LATENCY        = 2
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      dmem_req_i,
  input  logic                      dmem_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [MEM_DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [MEM_DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                      dmem_ack_o,
  output logic                      dmem_err_o
);

  localparam int unsigned IW  = $clog2(DEPTH);
  localparam logic [3:0]  LAT = 4'(LATENCY);

  dmem_state_t               state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      we_q, we_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                      in_range;
  logic                      mem_we;
  logic [MEM_DATA_WIDTH-1:0] mem_rdata;

  // Range check is done on the full captured address before indexing.
  assign in_range = 64'(addr_q) < 64'(DEPTH);

  dmem_array #(
    .DEPTH (DEPTH),
    .WIDTH (MEM_DATA_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .we_i    (mem_we),
    .waddr_i (addr_q[IW-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (addr_q[IW-1:0]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_we       = 1'b0;
    dmem_ack_o   = 1'b0;
    dmem_err_o   = 1'b0;
    dmem_rdata_o = '0;

    unique case (state_q)
      IDLE: begin
        if (dmem_req_i) begin
          we_d    = dmem_we_i;
          addr_d  = dmem_addr_i;
          wdata_d = dmem_wdata_i;
          cnt_d   = LAT;
          state_d = (LAT != 4'd0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ACK;
        end
      end
      ACK: begin
        dmem_ack_o   = 1'b1;
        dmem_err_o   = ~in_range;
        dmem_rdata_o = (!we_q && in_range) ? mem_rdata : '0;
        // Write lands on the edge that leaves ACK.
        mem_we       = we_q && in_range;
        cnt_d        = '0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (LATENCY=2 main instance, LATENCY=0 side instance).
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ack, err;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [31:0] rdata0;
  logic        ack0, err0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model_mem [64];

  data_mem_responder #(
    .MEM_ADDR_WIDTH (32),
    .MEM_DATA_WIDTH (32),
    .DEPTH          (64),
    .LATENCY        (2)
  ) dut (
    .clk_i        (clk),
    .arst_ni      (rst_n),
    .dmem_req_i   (req),
    .dmem_we_i    (we),
    .dmem_addr_i  (addr),
    .dmem_wdata_i (wdata),
    .dmem_rdata_o (rdata),
    .dmem_ack_o   (ack),
    .dmem_err_o   (err)
  );

  data_mem_responder #(
    .MEM_ADDR_WIDTH (32),
    .MEM_DATA_WIDTH (32),
    .DEPTH          (64),
    .LATENCY        (0)
  ) dut0 (
    .clk_i        (clk),
    .arst_ni      (rst_n),
    .dmem_req_i   (req0),
    .dmem_we_i    (we0),
    .dmem_addr_i  (addr0),
    .dmem_wdata_i (wdata0),
    .dmem_rdata_o (rdata0),
    .dmem_ack_o   (ack0),
    .dmem_err_o   (err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every ack pops one expectation; outside ack, outputs must be zero.
  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_ack: got ack=1 err=%b rdata=%h, required no ack", err, rdata);
      end else begin
        e = sb.pop_front();
        if ({err, rdata} !== {e.err, e.rdata}) begin
          n_bad++;
          $display("FAIL ack_payload: got err=%b rdata=%h, required err=%b rdata=%h",
                   err, rdata, e.err, e.rdata);
        end
      end
    end else if ({ack, err, rdata} !== 34'd0) begin
      n_bad++;
      $display("FAIL idle_outputs: got ack=%b err=%b rdata=%h, required all zero", ack, err, rdata);
    end
  end

  // Drives one request for a single cycle, scrambles inputs after capture,
  // and returns the number of rising edges from request to observed ack.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, output int n);
    exp_t e;
    e.err   = (a >= 32'd64);
    e.rdata = (w || a >= 32'd64) ? 32'd0 : model_mem[a[5:0]];
    if (w && a < 32'd64) model_mem[a[5:0]] = d;
    sb.push_back(e);
    req = 1'b1; we = w; addr = a; wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
      end
    end while (ack !== 1'b1 && n < 40);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 0; we = 0; addr = '0; wdata = '0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    foreach (model_mem[i]) model_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ack, err, rdata} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ack=%b err=%b rdata=%h, required zero", ack, err, rdata);
    end
    n_cmp++;
    if ({ack0, err0, rdata0} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_outputs_lat0: got ack=%b err=%b rdata=%h, required zero", ack0, err0, rdata0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latency0();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0;
    @(posedge clk); #1;
    req0 = 1'b0;
    n_cmp++;
    if ({ack0, err0, rdata0} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL lat0_read0: got ack=%b err=%b rdata=%h, required ack=1 err=0 rdata=0", ack0, err0, rdata0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ack0 !== 1'b0) begin
      n_bad++;
      $display("FAIL lat0_ack_width: got ack=%b, required 0", ack0);
    end
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd1; wdata0 = 32'hCAFEF00D;
    @(posedge clk); #1;
    req0 = 1'b0;
    n_cmp++;
    if ({ack0, rdata0} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL lat0_write_ack: got ack=%b rdata=%h, required ack=1 rdata=0", ack0, rdata0);
    end
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1;
    @(posedge clk); #1;
    req0 = 1'b0;
    n_cmp++;
    if ({ack0, rdata0} !== {1'b1, 32'hCAFEF00D}) begin
      n_bad++;
      $display("FAIL lat0_readback: got ack=%b rdata=%h, required ack=1 rdata=cafef00d", ack0, rdata0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int n;
    txn(1'b0, 32'd0, 32'd0, n);
    n_cmp++;
    if (n !== 3) begin
      n_bad++;
      $display("FAIL first_capture_latency: got %0d edges, required 3", n);
    end
    txn(1'b1, 32'd5, 32'hDEADBEEF, n);
    n_cmp++;
    if (n !== 3) begin
      n_bad++;
      $display("FAIL write_latency: got %0d edges, required 3", n);
    end
    txn(1'b0, 32'd5, 32'd0, n);
    n_cmp++;
    if (n !== 3) begin
      n_bad++;
      $display("FAIL read_latency: got %0d edges, required 3", n);
    end
  endtask

  task automatic test_out_of_range();
    int n;
    txn(1'b1, 32'd64, 32'hAAAA5555, n);
    n_cmp++;
    if (n !== 3) begin
      n_bad++;
      $display("FAIL oor_write_latency: got %0d edges, required 3", n);
    end
    txn(1'b0, 32'd64, 32'd0, n);
    txn(1'b0, 32'd0, 32'd0, n);
    txn(1'b0, 32'h8000_0005, 32'd0, n);
    n_cmp++;
    if (n !== 3) begin
      n_bad++;
      $display("FAIL oor_read_latency: got %0d edges, required 3", n);
    end
  endtask

  task automatic test_req_pulse();
    int n;
    txn(1'b1, 32'd7, 32'h0000_1234, n);
    txn(1'b0, 32'd7, 32'd0, n);
    txn(1'b0, 32'd8, 32'd0, n);
    txn(1'b0, 32'd5, 32'd0, n);
    n_cmp++;
    if (n !== 3) begin
      n_bad++;
      $display("FAIL pulse_read_latency: got %0d edges, required 3", n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [15:0] seen;
    logic [15:0] want;
    exp_t e;
    txn(1'b1, 32'd3, 32'h0300_00A5, n);
    e.err = 1'b0;
    e.rdata = model_mem[3];
    repeat (3) sb.push_back(e);
    want = 16'b0000_0100_0100_0100;
    seen = '0;
    req = 1'b1; we = 1'b0; addr = 32'd3; wdata = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      seen[i] = ack;
      if (i == 11) req = 1'b0;
    end
    n_cmp++;
    if (seen !== want) begin
      n_bad++;
      $display("FAIL back_to_back_pattern: got %b, required %b", seen, want);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int acks;
    req = 1'b1; we = 1'b1; addr = 32'd9; wdata = 32'h0000_FFFF;
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    foreach (model_mem[i]) model_mem[i] = '0;
    acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_bad++;
      $display("FAIL reset_abort_ack: got %0d acks, required 0", acks);
    end
    txn(1'b0, 32'd9, 32'd0, n);
    txn(1'b0, 32'd5, 32'd0, n);
    n_cmp++;
    if (n !== 3) begin
      n_bad++;
      $display("FAIL post_reset_latency: got %0d edges, required 3", n);
    end
  endtask

  initial begin
    test_reset();
    test_latency0();
    test_write_read();
    test_out_of_range();
    test_req_pulse();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
